seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a common-cathode multi-digit 7-segment PMOD.
- Accepts a frame of per-digit 5-bit display codes plus decimal points over a valid/ready handshake.
- Double-buffers the frame and commits it only at frame boundaries, so the display never tears.
- Cycles one-hot digit enables, with a blanking gap before each digit to suppress ghosting.
- Converts codes to segment patterns through the existing hexdigit decoder.

---
 rtl/seg7_pkg.sv | 10 +
 rtl/hexdigit.sv | 36 +++
 rtl/seg7_scan_ctrl.sv | 104 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared code constants and scan state type for the 7-segment scan controller
package seg7_pkg;
    localparam int CODE_W = 5;
    localparam logic [CODE_W-1:0] CODE_ALL_ON     = 5'd16;
    localparam logic [CODE_W-1:0] CODE_MINUS      = 5'd17;
    localparam logic [CODE_W-1:0] CODE_UNDERSCORE = 5'd18;
    localparam logic [CODE_W-1:0] CODE_S          = 5'd19;
    localparam logic [CODE_W-1:0] CODE_OFF        = 5'd20;
    typedef enum logic {BLANK, DRIVE} scan_state_t;
endpackage

// File: rtl/hexdigit.sv
// hexdigit: display code to {dp,g,f,e,d,c,b,a} pattern; dp only honoured for hex codes
module hexdigit
    import seg7_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              dp,
    output logic [7:0]        seg
);
    logic [6:0] pat;
    always_comb begin
        case (code)
            5'd0:            pat = 7'h3F;
            5'd1:            pat = 7'h06;
            5'd2:            pat = 7'h5B;
            5'd3:            pat = 7'h4F;
            5'd4:            pat = 7'h66;
            5'd5:            pat = 7'h6D;
            5'd6:            pat = 7'h7D;
            5'd7:            pat = 7'h07;
            5'd8:            pat = 7'h7F;
            5'd9:            pat = 7'h6F;
            5'd10:           pat = 7'h77;
            5'd11:           pat = 7'h7C;
            5'd12:           pat = 7'h39;
            5'd13:           pat = 7'h5E;
            5'd14:           pat = 7'h79;
            5'd15:           pat = 7'h71;
            CODE_ALL_ON:     pat = 7'h7F;
            CODE_MINUS:      pat = 7'h40;
            CODE_UNDERSCORE: pat = 7'h08;
            CODE_S:          pat = 7'h6D;
            default:         pat = 7'h00;
        endcase
    end
    assign seg = {code == CODE_ALL_ON || (code < 5'd16 && dp), pat};
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: double-buffered time-multiplexed scan of a common-cathode 7-segment display
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int DWELL_CYCLES = 25000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [CODE_W*DIGITS-1:0] load_codes,
    input  logic [DIGITS-1:0]        load_dp,
    input  logic                     lz_blank,
    output logic [7:0]               seg,
    output logic [DIGITS-1:0]        dig_en,
    output logic                     frame_tick
);
    localparam int MAXC  = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam scan_state_t      START      = BLANK_CYCLES > 0 ? BLANK : DRIVE;

    scan_state_t               state, nxt_state;
    logic [CNT_W-1:0]          cnt, nxt_cnt;
    logic [IDX_W-1:0]          idx, nxt_idx;
    logic [CODE_W*DIGITS-1:0]  disp_codes, nxt_codes, pend_codes;
    logic [DIGITS-1:0]         disp_dp, nxt_dp, pend_dp;
    logic                      pend_lz, pend_full;
    logic                      last, boundary, commit;
    logic [7:0]                dec_seg;

    // Blank zero digits from the top down until the first digit carrying a value or a dp.
    function automatic logic [CODE_W*DIGITS-1:0] lz_strip(
        input logic [CODE_W*DIGITS-1:0] c,
        input logic [DIGITS-1:0]        dp
    );
        logic run;
        run      = 1'b1;
        lz_strip = c;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run = run && c[i*CODE_W +: CODE_W] == '0 && !dp[i];
            if (run) lz_strip[i*CODE_W +: CODE_W] = CODE_OFF;
        end
    endfunction

    assign load_ready = !pend_full;

    always_comb begin
        last      = state == BLANK ? cnt == BLANK_LAST : cnt == DWELL_LAST;
        boundary  = state == DRIVE && last && idx == IDX_LAST;
        commit    = boundary && pend_full;
        nxt_cnt   = last ? '0 : cnt + 1'b1;
        nxt_state = !last ? state : state == BLANK ? DRIVE : START;
        nxt_idx   = !(state == DRIVE && last) ? idx : boundary ? '0 : idx + 1'b1;
        nxt_codes = commit ? (pend_lz ? lz_strip(pend_codes, pend_dp) : pend_codes) : disp_codes;
        nxt_dp    = commit ? pend_dp : disp_dp;
    end

    // Decoding the next-cycle digit lets seg/dig_en update together on the entry edge.
    hexdigit u_dec (
        .code (nxt_codes[nxt_idx*CODE_W +: CODE_W]),
        .dp   (nxt_dp[nxt_idx]),
        .seg  (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= START;
            cnt        <= '0;
            idx        <= '0;
            disp_codes <= {DIGITS{CODE_OFF}};
            disp_dp    <= '0;
            pend_codes <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            pend_full  <= 1'b0;
            seg        <= '0;
            dig_en     <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            disp_codes <= nxt_codes;
            disp_dp    <= nxt_dp;
            frame_tick <= boundary;
            dig_en     <= nxt_state == DRIVE ? DIGITS'(1) << nxt_idx : '0;
            seg        <= nxt_state == DRIVE ? dec_seg : '0;
            if (commit) begin
                pend_full <= 1'b0;
            end else if (load_valid && !pend_full) begin
                pend_full  <= 1'b1;
                pend_codes <= load_codes;
                pend_dp    <= load_dp;
                pend_lz    <= lz_blank;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table vectors, back-pressure, reset and random frames against a position-based model
module tb_seg7_scan_ctrl;
    localparam int D = 4, DW = 8, BL = 2;
    localparam int SLOT = DW + BL, FRAME = D * SLOT, FRAME2 = D * DW;

    logic        clk = 1'b0, rst_n = 1'b1, load_valid = 1'b0, lz_blank = 1'b0;
    logic [19:0] load_codes = '0;
    logic [3:0]  load_dp = '0;
    logic        load_ready, frame_tick, ready2, tick2;
    logic [7:0]  seg, seg2;
    logic [3:0]  dig_en, dig_en2;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIGITS(D), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_codes(load_codes), .load_dp(load_dp), .lz_blank(lz_blank),
        .seg(seg), .dig_en(dig_en), .frame_tick(frame_tick)
    );

    seg7_scan_ctrl #(.DIGITS(D), .DWELL_CYCLES(DW), .BLANK_CYCLES(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready2),
        .load_codes(load_codes), .load_dp(load_dp), .lz_blank(lz_blank),
        .seg(seg2), .dig_en(dig_en2), .frame_tick(tick2)
    );

    typedef struct packed {
        logic [19:0] codes;
        logic [3:0]  dp;
        logic        lz;
        logic [31:0] want;
    } vec_t;

    vec_t        vt [8];
    int          checks = 0, errors = 0;
    int          k, k2;
    bit          m_full;
    logic [19:0] shown_c, pend_c;
    logic [3:0]  shown_dp, pend_dp;
    logic        pend_lz;
    logic [7:0]  cap [4];
    logic [7:0]  hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    function automatic logic [19:0] mk(input int a3, input int a2, input int a1, input int a0);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic logic [7:0] seg_of(input logic [4:0] c, input logic dp);
        if (c < 16) return hex_tab[c[3:0]] | {dp, 7'b0};
        if (c == 16) return 8'hFF;
        if (c == 17) return 8'h40;
        if (c == 18) return 8'h08;
        if (c == 19) return 8'h6D;
        return 8'h00;
    endfunction

    // Highest digit holding a non-zero code or a dp; everything above it goes dark.
    function automatic logic [19:0] lz_codes(input logic [19:0] c, input logic [3:0] dp, input logic lz);
        int top = 0;
        logic [19:0] r = c;
        for (int i = 0; i < 4; i++) if (c[5*i +: 5] != 0 || dp[i]) top = i;
        if (lz) for (int i = top + 1; i < 4; i++) r[5*i +: 5] = 5'd20;
        return r;
    endfunction

    function automatic logic [31:0] exp_frame(input logic [19:0] c, input logic [3:0] dp, input logic lz);
        logic [19:0] r = lz_codes(c, dp, lz);
        logic [31:0] f;
        for (int i = 0; i < 4; i++) f[8*i +: 8] = seg_of(r[5*i +: 5], dp[i]);
        return f;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_seg", seg, 0);
        chk("rst_dig_en", dig_en, 0);
        chk("rst_tick", frame_tick, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_nb_seg", seg2, 0);
        chk("rst_nb_dig_en", dig_en2, 0);
        chk("rst_nb_ready", ready2, 1);
        @(negedge clk);
        load_valid = 1'b0;
        rst_n = 1'b1;
        k = 0;
        k2 = 0;
        m_full = 0;
        shown_c = mk(20, 20, 20, 20);
        shown_dp = '0;
    endtask

    task automatic step();
        bit acc;
        logic [19:0] c;
        logic [3:0] dp;
        logic lz;
        int pos, d, pos2;
        bit drv;
        acc = load_valid && !m_full;
        c = load_codes;
        dp = load_dp;
        lz = lz_blank;
        chk("load_ready", load_ready, !m_full);
        @(posedge clk);
        if (k % FRAME == FRAME - 1 && m_full) begin
            shown_c = lz_codes(pend_c, pend_dp, pend_lz);
            shown_dp = pend_dp;
            m_full = 0;
        end
        if (acc) begin
            pend_c = c;
            pend_dp = dp;
            pend_lz = lz;
            m_full = 1;
        end
        k++;
        k2++;
        @(negedge clk);
        pos = k % FRAME;
        d = pos / SLOT;
        drv = pos % SLOT >= BL;
        chk("dig_en", dig_en, drv ? 1 << d : 0);
        chk("seg", seg, drv ? seg_of(shown_c[5*d +: 5], shown_dp[d]) : 0);
        chk("frame_tick", frame_tick, pos == 0);
        if (pos % SLOT == SLOT / 2) cap[d] = seg;
        pos2 = k2 % FRAME2;
        chk("nb_dig_en", dig_en2, 1 << (pos2 / DW));
        chk("nb_tick", tick2, pos2 == 0);
    endtask

    task automatic load_frame(input logic [19:0] c, input logic [3:0] dp, input logic lz);
        int n = 0;
        while (!load_ready && n < 2 * FRAME) begin
            step();
            n++;
        end
        chk("load_wait", n < 2 * FRAME, 1);
        load_codes = c;
        load_dp = dp;
        lz_blank = lz;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] want);
        step();
        while (k % FRAME != 0) step();
        repeat (FRAME) step();
        for (int i = 0; i < 4; i++) chk($sformatf("%s_d%0d", tag, i), cap[i], want[8*i +: 8]);
    endtask

    initial begin
        vt[0] = '{mk(1, 2, 3, 4),     4'b0000, 1'b0, 32'h065B4F66};
        vt[1] = '{mk(0, 0, 5, 0),     4'b0000, 1'b1, 32'h00006D3F};
        vt[2] = '{mk(0, 0, 0, 0),     4'b0000, 1'b1, 32'h0000003F};
        vt[3] = '{mk(0, 0, 0, 0),     4'b1000, 1'b1, 32'hBF3F3F3F};
        vt[4] = '{mk(10, 17, 16, 25), 4'b1010, 1'b0, 32'hF740FF00};
        vt[5] = '{mk(0, 0, 0, 0),     4'b0000, 1'b0, 32'h3F3F3F3F};
        vt[6] = '{mk(19, 18, 20, 15), 4'b0001, 1'b0, 32'h6D0800F1};
        vt[7] = '{mk(0, 7, 0, 0),     4'b0000, 1'b1, 32'h00073F3F};
        do_reset();
        repeat (FRAME + 5) step();
        for (int i = 0; i < 8; i++) begin
            load_frame(vt[i].codes, vt[i].dp, vt[i].lz);
            check_frame($sformatf("vec%0d", i), vt[i].want);
        end
        begin
            int n = 0;
            logic [19:0] ca = mk(8, 6, 4, 2), cb = mk(0, 0, 9, 1);
            while (k % FRAME != 3) step();
            load_frame(ca, 4'b0100, 1'b0);
            load_codes = cb;
            load_dp = 4'b0000;
            lz_blank = 1'b1;
            load_valid = 1'b1;
            while (!load_ready && n < 2 * FRAME) begin
                step();
                n++;
            end
            chk("bp_ready_pos", k % FRAME, 0);
            chk("bp_ready_tick", frame_tick, 1);
            step();
            load_valid = 1'b0;
            repeat (FRAME - 1) step();
            for (int i = 0; i < 4; i++)
                chk($sformatf("bp_A_d%0d", i), cap[i], exp_frame(ca, 4'b0100, 1'b0) >> (8 * i) & 32'hFF);
            check_frame("bp_B", exp_frame(cb, 4'b0000, 1'b1));
        end
        repeat (600) begin
            load_valid = $urandom_range(0, 3) == 0;
            load_codes = 20'($urandom);
            load_dp = 4'($urandom);
            lz_blank = 1'($urandom);
            step();
        end
        load_valid = 1'b0;
        load_frame(mk(1, 1, 1, 1), 4'b1111, 1'b0);
        repeat (5) step();
        do_reset();
        repeat (FRAME + 5) step();
        check_frame("post_reset_dark", 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
